// File: rtl/enemy_wave_ctrl.sv
// enemy_wave_ctrl: sequences one wave of enemy ships and arbitrates their fire permission.
//
// Ports:
//   i_clk        base clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_ani_stb    one-cycle strobe per animation frame
//   i_paused     game paused; frame strobes are ignored while high
//   i_hit        per-ship hit pulse from collision logic
//   i_firing     per-ship bullet-in-air flag
//   o_alive      ship present and drawn
//   o_animate    ship movement enable (same as o_alive)
//   o_fire_en    one-hot-or-zero fire permission
//   o_wave       current wave number, starts at 1, saturates at 255
//   o_score      accumulated kill score, saturates at 16'hFFFF
//   o_wave_clear one-cycle pulse on entering the clear phase
//
// A "tick" is a frame strobe while not paused. Spawning, cooldown and the clear hold advance on
// ticks only; kills act on any cycle.

module enemy_wave_ctrl #(
  parameter int unsigned N_SHIPS      = 4,
  parameter int unsigned SPAWN_GAP    = 20,
  parameter int unsigned FIRE_GAP     = 30,
  parameter int unsigned CLEAR_FRAMES = 60,
  parameter int unsigned KILL_PTS     = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_paused,
  input  logic [N_SHIPS-1:0] i_hit,
  input  logic [N_SHIPS-1:0] i_firing,
  output logic [N_SHIPS-1:0] o_alive,
  output logic [N_SHIPS-1:0] o_animate,
  output logic [N_SHIPS-1:0] o_fire_en,
  output logic [7:0]         o_wave,
  output logic [15:0]        o_score,
  output logic               o_wave_clear
);

  localparam int unsigned IW = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1;

  // Terminal counter values; a zero gap degenerates to one tick.
  localparam logic [15:0] SPAWN_RLD = 16'((SPAWN_GAP    > 0) ? SPAWN_GAP    - 1 : 0);
  localparam logic [15:0] COOL_LAST = 16'((FIRE_GAP     > 0) ? FIRE_GAP     - 1 : 0);
  localparam logic [15:0] CLR_LAST  = 16'((CLEAR_FRAMES > 0) ? CLEAR_FRAMES - 1 : 0);
  localparam logic [3:0]  NS        = 4'(N_SHIPS);

  typedef enum logic [1:0] {WvSpawn, WvActive, WvClear} wave_st_t;
  typedef enum logic [1:0] {ArbIdle, ArbGrant, ArbCool} arb_st_t;

  wave_st_t r_wave_st, w_wave_nxt;
  arb_st_t  r_arb_st,  w_arb_nxt;

  logic [N_SHIPS-1:0] r_alive;
  logic [N_SHIPS-1:0] r_firing_prev;
  logic [3:0]         r_spawn_idx;
  logic [15:0]        r_gap_cnt;
  logic [15:0]        r_clr_cnt;
  logic [15:0]        r_cool_cnt;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant_idx;
  logic [7:0]         r_wave;
  logic [15:0]        r_score;
  logic               r_wave_clear;

  logic               w_tick;
  logic [N_SHIPS-1:0] w_kill;
  logic [N_SHIPS-1:0] w_alive_eff;
  logic               w_spawn;
  logic [N_SHIPS-1:0] w_spawn_mask;
  logic [N_SHIPS-1:0] w_grant_mask;
  logic               w_grant_end;
  logic               w_arb_en;
  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [3:0]         w_kill_cnt;
  logic [31:0]        w_score_sum;

  assign w_tick = i_ani_stb & ~i_paused;

  // Kills are ignored during the clear phase; alive is empty there anyway.
  assign w_kill      = i_hit & r_alive & {N_SHIPS{r_wave_st != WvClear}};
  assign w_alive_eff = r_alive & ~w_kill;

  assign w_spawn      = (r_wave_st == WvSpawn) && w_tick && (r_gap_cnt == '0) && (r_spawn_idx < NS);
  assign w_spawn_mask = w_spawn ? (N_SHIPS'(1) << r_spawn_idx) : '0;

  // ---------------------------------------------------------------------------------------------
  // Wave FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wave_st <= WvSpawn;
    else       r_wave_st <= w_wave_nxt;
  end

  always_comb begin
    w_wave_nxt = r_wave_st;
    unique case (r_wave_st)
      WvSpawn: begin
        if (w_spawn && (r_spawn_idx == NS - 4'd1)) begin
          w_wave_nxt = WvActive;
        end else if ((r_spawn_idx >= NS) && (r_alive == '0)) begin
          // Everything spawned and already dead.
          w_wave_nxt = WvClear;
        end
      end
      WvActive: begin
        if (r_alive == '0) w_wave_nxt = WvClear;
      end
      WvClear: begin
        if (w_tick && (r_clr_cnt == CLR_LAST)) w_wave_nxt = WvSpawn;
      end
      default: w_wave_nxt = WvSpawn;
    endcase
  end

  always_comb begin
    o_alive      = r_alive;
    o_animate    = r_alive;
    o_wave       = r_wave;
    o_score      = r_score;
    o_wave_clear = r_wave_clear;
  end

  // Spawn sequencing: counters sit at zero outside SPAWN so every wave starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_wave_st != WvSpawn)) begin
      r_spawn_idx <= '0;
      r_gap_cnt   <= '0;
    end else if (w_tick) begin
      if (r_gap_cnt == '0) begin
        if (r_spawn_idx < NS) begin
          r_spawn_idx <= r_spawn_idx + 4'd1;
          r_gap_cnt   <= SPAWN_RLD;
        end
      end else begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_wave_st != WvClear)) r_clr_cnt <= '0;
    else if (w_tick)                     r_clr_cnt <= r_clr_cnt + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_alive <= '0;
    else       r_alive <= w_alive_eff | w_spawn_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wave       <= 8'd1;
      r_wave_clear <= 1'b0;
    end else begin
      r_wave_clear <= (r_wave_st != WvClear) && (w_wave_nxt == WvClear);
      if ((r_wave_st == WvClear) && (w_wave_nxt == WvSpawn) && (r_wave != 8'hFF)) begin
        r_wave <= r_wave + 8'd1;
      end
    end
  end

  // Score: every simultaneous kill counts.
  always_comb begin
    w_kill_cnt = '0;
    for (int unsigned i = 0; i < N_SHIPS; i++) begin
      w_kill_cnt = w_kill_cnt + 4'(w_kill[i]);
    end
  end

  assign w_score_sum = 32'(r_score) + 32'(w_kill_cnt) * KILL_PTS;

  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_score <= '0;
    else if (w_score_sum > 32'h0000FFFF) r_score <= 16'hFFFF;
    else                                r_score <= w_score_sum[15:0];
  end

  // ---------------------------------------------------------------------------------------------
  // Fire arbiter
  // ---------------------------------------------------------------------------------------------
  assign w_arb_en     = (r_wave_st != WvClear);
  assign w_grant_mask = N_SHIPS'(1) << r_grant_idx;
  // A dying ship must not keep its grant, hence the kill term.
  assign w_grant_end  = |(w_grant_mask & ((r_firing_prev & ~i_firing) | w_kill | ~r_alive));

  // Round-robin pick: first surviving ship at or after the pointer, wrapping.
  always_comb begin
    int unsigned c;
    c       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < N_SHIPS; i++) begin
      c = 32'(r_rr_ptr) + i;
      if (c >= N_SHIPS) c = c - N_SHIPS;
      if (!w_found && ((w_alive_eff & (N_SHIPS'(1) << c)) != '0)) begin
        w_found = 1'b1;
        w_pick  = IW'(c);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_arb_st <= ArbIdle;
    else       r_arb_st <= w_arb_nxt;
  end

  always_comb begin
    w_arb_nxt = r_arb_st;
    unique case (r_arb_st)
      ArbIdle:  if (w_tick && w_found) w_arb_nxt = ArbGrant;
      ArbGrant: if (w_grant_end) w_arb_nxt = ArbCool;
      ArbCool:  if (w_tick && (r_cool_cnt == COOL_LAST)) w_arb_nxt = ArbIdle;
      default:  w_arb_nxt = ArbIdle;
    endcase
    if (!w_arb_en) w_arb_nxt = ArbIdle;
  end

  always_comb begin
    o_fire_en = (r_arb_st == ArbGrant) ? (w_grant_mask & r_alive) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
    end else if ((r_arb_st == ArbIdle) && (w_arb_nxt == ArbGrant)) begin
      r_grant_idx <= w_pick;
      r_rr_ptr    <= (w_pick == IW'(N_SHIPS - 1)) ? '0 : w_pick + IW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_arb_st != ArbCool)) r_cool_cnt <= '0;
    else if (w_tick)                    r_cool_cnt <= r_cool_cnt + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_firing_prev <= '0;
    else       r_firing_prev <= i_firing;
  end

endmodule

// File: doc/enemy_wave_ctrl.md
ENEMY_WAVE_CTRL -- requirements
Module: enemy_wave_ctrl

Interface
REQ-001 Parameter N_SHIPS, default 4, number of enemy ships sequenced (1..8).
REQ-002 Parameter SPAWN_GAP, default 20, animation frames between successive ship spawns.
REQ-003 Parameter FIRE_GAP, default 30, cooldown frames between one fire grant ending and the next starting.
REQ-004 Parameter CLEAR_FRAMES, default 60, frames held in CLEAR before the next wave.
REQ-005 Parameter KILL_PTS, default 10, score added per kill.
REQ-006 i_clk  in  1  base clock; all logic on rising edge.
REQ-007 i_rst  in  1  synchronous, active-high reset.
REQ-008 i_ani_stb  in  1  one-cycle animation strobe, one per frame.
REQ-009 i_paused  in  1  high while game paused.
REQ-010 i_hit  in  N_SHIPS  per-ship hit pulse from collision logic, one bit per ship.
REQ-011 i_firing  in  N_SHIPS  per-ship bullet-in-air flag from each ship.
REQ-012 o_alive  out  N_SHIPS  ship present and drawn.
REQ-013 o_animate  out  N_SHIPS  ship movement enable; equals o_alive.
REQ-014 o_fire_en  out  N_SHIPS  one-hot-or-zero fire permission, drives each ship's fire enable.
REQ-015 o_wave  out  8  current wave number, starts at 1.
REQ-016 o_score  out  16  accumulated kill score.
REQ-017 o_wave_clear  out  1  one-cycle pulse on entering CLEAR.

Function
REQ-018 "Tick" SHALL mean i_ani_stb=1 and i_paused=0; all counters advance only on ticks.
REQ-019 Wave FSM states SHALL be SPAWN, ACTIVE and CLEAR.
REQ-020 SPAWN: on the first tick, ship 0 SHALL become alive; ship k SHALL become alive k*SPAWN_GAP ticks after ship 0.
REQ-021 SPAWN->ACTIVE SHALL occur on the tick that makes ship N_SHIPS-1 alive.
REQ-022 ACTIVE->CLEAR SHALL occur in the cycle after o_alive becomes all-zero; o_wave_clear SHALL pulse for one cycle on that transition.
REQ-023 SPAWN SHALL also go to CLEAR if every spawned ship is dead and no ships remain to spawn.
REQ-024 CLEAR SHALL last CLEAR_FRAMES ticks, then increment o_wave (saturating at 255) and enter SPAWN with the spawn counter cleared.
REQ-025 A kill SHALL occur when i_hit[k]=1 and o_alive[k]=1 in the same cycle, independent of ticks and pause; o_alive[k] SHALL clear on the next edge.
REQ-026 Hits on dead ships, and hits while in CLEAR, SHALL be ignored.
REQ-027 Simultaneous kills SHALL each add KILL_PTS in the same cycle (popcount*KILL_PTS); o_score SHALL saturate at 16'hFFFF.
REQ-028 The fire arbiter SHALL have states IDLE, GRANT and COOL.
REQ-029 IDLE: on a tick with any ship alive, the arbiter SHALL grant the first alive ship at or after the round-robin pointer, wrapping; the pointer SHALL then be set to the granted index+1 mod N_SHIPS.
REQ-030 GRANT: o_fire_en SHALL be one-hot on the granted ship.
REQ-031 GRANT SHALL end when the granted ship's i_firing falls 1->0, or when that ship is killed; either event SHALL clear o_fire_en on the next edge and enter COOL.
REQ-032 COOL SHALL last FIRE_GAP ticks, then return to IDLE.
REQ-033 Outside ACTIVE/SPAWN, o_fire_en SHALL be zero and the arbiter SHALL be forced to IDLE.
REQ-034 o_fire_en SHALL never have more than one bit set, and never a bit set for a dead ship.

Reset
REQ-035 On i_rst, SHALL set: o_alive=0, o_fire_en=0, o_wave=1, o_score=0, o_wave_clear=0, wave FSM=SPAWN, arbiter=IDLE, pointer=0, all counters=0.
REQ-036 i_rst SHALL take priority over hits and ticks in the same cycle, including mid-wave and mid-grant.

Verification
REQ-037 Reset, then 61 ticks with N_SHIPS=4 and SPAWN_GAP=20 -> ships alive at ticks 1, 21, 41, 61; state ACTIVE after tick 61.
REQ-038 All alive; i_hit=4'b0101 for one cycle -> o_alive=4'b1010, o_score=20.
REQ-039 Ship 0 granted; i_firing[0] goes 0->1->0 -> o_fire_en=0; after 30 ticks ship 1 is granted.
REQ-040 Granted ship 2 killed -> o_fire_en=0 next cycle, COOL entered; next grant goes to ship 3 (or the next alive ship).
REQ-041 Last ship killed -> o_wave_clear one pulse; after 60 ticks o_wave=2 and ship 0 respawns on the next tick.
REQ-042 i_paused=1 with strobes running -> no spawn, cooldown or clear progress; hits still kill and score.
